// File: rtl/context_switch_scheduler.sv
// rtl/context_switch_scheduler.sv - write/wait/read context-switch sequencer for the link edge memories
// Optional completion counter: define CONTEXT_SWITCH_COUNTER_EN to add the switch_count port.
module context_switch_scheduler #(
  parameter int NUM_CONTEXTS = 2,
  parameter int MEM_LATENCY  = 1,
  parameter int CTX_WIDTH    = 4,
  parameter int STAGE_WIDTH  = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE          = '0,
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM  = STAGE_WIDTH'(6),
  parameter logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM = STAGE_WIDTH'(7)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] stage_in,
  input  logic                   switch_req,
  input  logic                   switch_local,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   local_context_switch,
  output logic                   switch_ack,
  output logic                   busy,
  output logic [CTX_WIDTH-1:0]   current_context
`ifdef CONTEXT_SWITCH_COUNTER_EN
  ,
  output logic [15:0]            switch_count
`endif
);

  typedef enum logic [2:0] {
    ST_PASS,
    ST_WRITE,
    ST_WAIT,
    ST_READ,
    ST_DONE
  } state_t;

  localparam logic [CTX_WIDTH-1:0] LAST_CTX  = CTX_WIDTH'(NUM_CONTEXTS - 1);
  localparam logic [1:0]           WAIT_LOAD = 2'(MEM_LATENCY - 1);

  state_t                   state;
  state_t                   state_next;
  logic                     loc_q;
  logic                     loc_next;
  logic [1:0]               wait_cnt;
  logic [1:0]               cnt_next;
  logic [STAGE_WIDTH-1:0]   gs_next;
  logic                     lcs_next;
  logic                     ack_next;
  logic                     busy_next;
  logic [CTX_WIDTH-1:0]     ctx_next;

  // Outputs are registered from the next-state decode so each stage appears
  // exactly one cycle after the edge that chose it.
  always_comb begin
    state_next = state;
    loc_next   = loc_q;
    cnt_next   = wait_cnt;
    gs_next    = global_stage;
    lcs_next   = local_context_switch;
    ack_next   = 1'b0;
    busy_next  = busy;
    ctx_next   = current_context;

    case (state)
      ST_PASS: begin
        gs_next   = stage_in;
        lcs_next  = 1'b0;
        busy_next = 1'b0;
        if (switch_req && (stage_in == STAGE_IDLE)) begin
          state_next = ST_WRITE;
          gs_next    = STAGE_WRITE_TO_MEM;
          lcs_next   = switch_local;
          loc_next   = switch_local;
          busy_next  = 1'b1;
        end
      end

      ST_WRITE: begin
        // Local switches bypass the RAM, so there is no read latency to cover.
        if (loc_q) begin
          state_next = ST_READ;
          gs_next    = STAGE_READ_FROM_MEM;
        end else begin
          state_next = ST_WAIT;
          gs_next    = STAGE_IDLE;
          cnt_next   = WAIT_LOAD;
        end
      end

      ST_WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_next = ST_READ;
          gs_next    = STAGE_READ_FROM_MEM;
        end else begin
          cnt_next = wait_cnt - 2'd1;
          gs_next  = STAGE_IDLE;
        end
      end

      ST_READ: begin
        state_next = ST_DONE;
        gs_next    = STAGE_IDLE;
        lcs_next   = 1'b0;
        ack_next   = 1'b1;
        if (!loc_q) begin
          ctx_next = (current_context == LAST_CTX) ? '0
                                                   : current_context + CTX_WIDTH'(1);
        end
      end

      ST_DONE: begin
        // stage_in is still ignored here; the first PASS cycle shows IDLE.
        state_next = ST_PASS;
        gs_next    = STAGE_IDLE;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = ST_PASS;
        gs_next    = STAGE_IDLE;
        lcs_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= ST_PASS;
      loc_q                <= 1'b0;
      wait_cnt             <= 2'd0;
      global_stage         <= STAGE_IDLE;
      local_context_switch <= 1'b0;
      switch_ack           <= 1'b0;
      busy                 <= 1'b0;
      current_context      <= '0;
    end else begin
      state                <= state_next;
      loc_q                <= loc_next;
      wait_cnt             <= cnt_next;
      global_stage         <= gs_next;
      local_context_switch <= lcs_next;
      switch_ack           <= ack_next;
      busy                 <= busy_next;
      current_context      <= ctx_next;
    end
  end

`ifdef CONTEXT_SWITCH_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      switch_count <= 16'd0;
    end else if ((state == ST_READ) && !loc_q && (switch_count != 16'hFFFF)) begin
      switch_count <= switch_count + 16'd1;
    end
  end
`else
  // No completion counter in this build.
`endif

endmodule
